// File: rtl/imm_sequence_feeder.sv
// Queues host operands in a small FIFO and replays the immediate schedule
// (operand, 0, 0, 1, 0) per operand into the additive-inverse processor.
module imm_sequence_feeder #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int OP_CYCLES = 5,
  parameter int ONE_SLOT  = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           imm,
  output logic                       proc_reset,
  output logic                       busy,
  output logic                       op_done,
  output logic [7:0]                 ops_count,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(OP_CYCLES);

  // Host handshake: an operand transfers on a rising edge where in_valid and
  // in_ready are both high; in_data/in_valid are held by the host until then.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [WIDTH-1:0] op_reg_q, op_reg_d;
  logic [7:0]       ops_q, ops_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;

  logic push, pop, last_slot, have_op;

  assign in_ready   = (level_q != (AW+1)'(DEPTH));
  assign push       = in_valid && in_ready;
  assign have_op    = (level_q != '0);
  assign last_slot  = (slot_q == SW'(OP_CYCLES-1));
  assign fifo_level = level_q;
  assign ops_count  = ops_q;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    op_reg_d   = op_reg_q;
    ops_d      = ops_q;
    pop        = 1'b0;
    imm        = '0;
    proc_reset = 1'b1;
    busy       = 1'b0;
    op_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (have_op) begin
          pop      = 1'b1;
          op_reg_d = mem_q[rd_ptr_q];
          slot_d   = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        proc_reset = 1'b0;
        busy       = 1'b1;
        if (slot_q == '0) begin
          imm = op_reg_q;
        end else if (slot_q == SW'(ONE_SLOT)) begin
          imm = WIDTH'(1);
        end
        if (last_slot) begin
          op_done = 1'b1;
          ops_d   = ops_q + 8'd1;
          slot_d  = '0;
          // Chain straight into the next operation so proc_reset never pulses.
          if (have_op) begin
            pop      = 1'b1;
            op_reg_d = mem_q[rd_ptr_q];
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (pop && !push) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      slot_q   <= '0;
      op_reg_q <= '0;
      ops_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      op_reg_q <= op_reg_d;
      ops_q    <= ops_d;
      level_q  <= level_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Storage needs no reset: an empty level makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: doc/imm_sequence_feeder.md
Name: imm_sequence_feeder

Overview:
- Upstream stage that drives the additive-inverse processor's `imm` input and its active-high reset.
- A host pushes 4-bit operands through a valid/ready handshake into a small FIFO.
- For each operand, the feeder replays the fixed per-operation immediate schedule (operand, 0, 0, 1, 0) for one processor pass.
- Operations run back-to-back with no gap while operands remain; the processor is held in reset when idle.

Parameters:
- WIDTH, 4: operand and imm width in bits.
- DEPTH, 4: FIFO entries; a power of 2, at least 2.
- OP_CYCLES, 5: cycles per processor operation; at least 4.
- ONE_SLOT, 3: slot index at which imm = 1; must satisfy 0 < ONE_SLOT < OP_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  host operand valid.
- in_data  in  WIDTH  host operand.
- in_ready  out  1  FIFO can accept; equals !full.
- imm  out  WIDTH  immediate to the processor.
- proc_reset  out  1  active-high reset to the processor.
- busy  out  1  high while in RUN.
- op_done  out  1  one-cycle pulse in the last slot of each operation.
- ops_count  out  8  completed operations, wrapping.
- fifo_level  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is asynchronous, active-low, and clears immediately, even mid-operation:
  - FIFO empty, fifo_level = 0, in_ready = 1.
  - state = IDLE, slot = 0, op_reg = 0.
  - imm = 0, proc_reset = 1, busy = 0, op_done = 0, ops_count = 0.
  - Operands queued or in flight are discarded.
- Push: an operand is written when in_valid && in_ready at a rising edge.
  - in_ready is low when full, so a push to a full FIFO never occurs.
  - Held in_data/in_valid with in_ready low is not lost; it is taken once ready rises.
- Pop: occurs only on an FSM transition into slot 0 and requires fifo_level != 0, sampled before the edge.
  - A push and a pop in the same cycle leave the level unchanged.
  - The FIFO is ordered first-in, first-out.
- FSM states are IDLE and RUN.
  - IDLE:
    - Outputs: imm = 0, proc_reset = 1, busy = 0.
    - If fifo_level != 0: pop into op_reg, slot <= 0, go to RUN.
  - RUN:
    - Outputs: proc_reset = 0, busy = 1.
    - imm = op_reg when slot = 0; imm = 1 when slot = ONE_SLOT; imm = 0 otherwise.
    - slot increments each cycle.
    - At slot = OP_CYCLES-1: op_done = 1 and ops_count increments (255 -> 0).
      - If fifo_level != 0: pop, slot <= 0, stay in RUN. This is back-to-back, with no IDLE cycle and proc_reset staying 0.
      - Otherwise go to IDLE.
- Outputs imm, proc_reset, busy and op_done decode combinationally from registered state, slot and op_reg only; there is no in_* to output path.
- Latency:
  - Push accepted at edge N into an empty FIFO in IDLE: pop at edge N+1; imm = operand and proc_reset = 0 during the cycle after N+1.
  - Operation length is exactly OP_CYCLES cycles.
- Operand value 0 is legal: slot 0 drives imm = 0.
- The schedule is unaffected by pushes during RUN.

Test Plan:
- Reset release with FIFO empty, held 10 cycles:
  - imm = 0, proc_reset = 1, busy = 0, in_ready = 1, ops_count = 0 throughout.
- Push 5 at edge N:
  - From the cycle after N+1, imm sequence is 5, 0, 0, 1, 0.
  - proc_reset = 0 for those 5 cycles; op_done is high in the 5th cycle only.
  - Then IDLE: proc_reset = 1, ops_count = 1.
- Push 5, 3, 7 on consecutive cycles:
  - imm is 5,0,0,1,0,3,0,0,1,0,7,0,0,1,0 with no gap.
  - proc_reset stays 0 for 15 cycles; ops_count = 3.
  - fifo_level peaks at 2.
- Hold in_valid high with values 1..6:
  - in_ready drops once 4 entries are queued behind the running operation.
  - All 6 operands emerge in order 1..6; none is dropped or duplicated.
- Deassert reset_n during slot 2 of operand 9 with 2 operands queued:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - fifo_level = 0.
  - After release, no operation runs until a new push.
- Complete 256 operations (operand 0):
  - ops_count wraps to 0.
  - Slot 0 of each operation drives imm = 0; slot 3 still drives 1.
